vscale_md_iter: RTL
===================

# vscale_md_iter

Iterative multiply/divide responder for the vscale core. It answers the `md_req_*` / `md_resp_*` handshake that the pipeline control drives from DX and waits on in WB. It implements RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on a one-bit-per-cycle datapath. It sits beside the ALU in the datapath, takes operands from the bypassed rs1/rs2 values, and returns its result to the WB mux (`WB_SRC_MD`).

## Interface
Parameters:
- none; width fixed at 32 (`XPR_LEN`).

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present (ctrl `md_req_valid`, already kill-qualified).
- `req_ready`  out  1  unit can accept a request.
- `req_op`  in  `MD_OP_WIDTH`(2)  operation: `MD_OP_MUL`=0, `MD_OP_DIV`=1, `MD_OP_REM`=2.
- `req_in_1_signed`  in  1  treat operand 1 as two's complement.
- `req_in_2_signed`  in  1  treat operand 2 as two's complement.
- `req_out_sel`  in  `MD_OUT_SEL_WIDTH`(2)  result select: `MD_OUT_LO`=0, `MD_OUT_HI`=1, `MD_OUT_REM`=2.
- `req_in_1`  in  32  operand 1 (rs1): multiplicand or dividend.
- `req_in_2`  in  32  operand 2 (rs2): multiplier or divisor.
- `kill`  in  1  abort any in-flight operation (exception or interrupt flush).
- `resp_valid`  out  1  result valid this cycle.
- `resp_result`  out  32  result.

## Operation
State machine:
- `IDLE`: `req_ready`=1. Accept on `req_valid && !kill`.
  - Latch op, out_sel, `|in_1|`, `|in_2|` (magnitude only when the signed flag is set and the MSB is 1), and `in2_zero`.
  - `negate_q` = (s1 & in_1[31]) ^ (s2 & in_2[31]); `negate_r` = s1 & in_1[31].
  - Clear the 64-bit accumulator and the 5-bit counter. Go to `COMPUTE`.
- `COMPUTE`: 32 iterations; counter runs 0..31 and wraps to 0 on exit.
  - MUL: shift-add. If the multiplier LSB is 1, add the multiplicand to accumulator[63:32] with the carry kept. Then shift the {accumulator, multiplier} pair right by 1.
  - DIV/REM: restoring division. Shift {rem, dividend} left by 1. If rem ≥ divisor, subtract and set quotient bit = 1.
  - Arithmetic is 33 bits wide to keep the carry/borrow. At count 31 go to `FINAL`.
- `FINAL`: sign correction, then register the selected result into `resp_result`. Go to `DONE`.
  - MUL: negate the 64-bit product if `negate_q`. Select [31:0] for LO, [63:32] for HI.
  - DIV: negate the quotient if `negate_q && !in2_zero`.
  - REM: negate the remainder if `negate_r`.
- `DONE`: `resp_valid`=1 for exactly one cycle, then go to `IDLE`.
- `req_ready` = (state == `IDLE`), combinational from registered state.

RV32M corner cases fall out of the datapath; no extra muxing:
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
- 0x80000000 / 0xFFFFFFFF (signed): quotient = 0x80000000, remainder = 0.

`kill`:
- In any state, `kill` returns the machine to `IDLE` on the next edge.
- `resp_valid` is not asserted for the killed operation. `resp_result` keeps its old value.
- If `kill` and `req_valid` are high in the same cycle, the request is not accepted.

## Timing
- Accept edge = cycle 0. `COMPUTE` occupies cycles 1–32, `FINAL` cycle 33, `DONE` cycle 34 (`resp_valid`=1). `IDLE` in cycle 35.
- Latency is fixed: 34 cycles from acceptance to `resp_valid`.
- Throughput: one operation per 35 cycles. No back-to-back acceptance.
- `resp_result` holds its value from `DONE` until the next `FINAL`.
- Reset values: state `IDLE`, `req_ready`=1, `resp_valid`=0, `resp_result`=0, counter 0.
- Reset mid-operation behaves exactly like `kill`.
- Operand ports are only sampled on the accept edge. Changes afterwards have no effect.

## Structure
- `MD_OP_*`, `MD_OUT_*` and their widths come from the shared md constants header.
- Add state encodings `MD_STATE_IDLE/COMPUTE/FINAL/DONE` and `MD_STATE_WIDTH`(2) to that header.
- Single module. No sub-module; the 33-bit add/sub is inline.

## Test plan
- MULH, s1=s2=1, in_1=0xFFFFFFFF, in_2=0x00000002 → at cycle 34 `resp_result`=0xFFFFFFFF. MUL with the same operands → 0xFFFFFFFE.
- MULHU, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU, in_1=0xFFFFFFFF (signed) × in_2=0xFFFFFFFF → 0xFFFFFFFF.
- DIV, signed, -7 / 2 → 0xFFFFFFFD. REM, signed, same operands → 0xFFFFFFFF. DIVU 7/2 → 3.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF. REM -5/0 → 0xFFFFFFFB. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- `kill` asserted in cycle 10 of a DIV → `IDLE` and `req_ready`=1 at cycle 11. `resp_valid` never rises and `resp_result` is unchanged. A following MUL 3×4 returns 12 at latency 34.
- `reset` mid-COMPUTE → all outputs at reset values next cycle. `req_valid` held high during busy cycles is ignored until `req_ready`=1.

Source files
------------

// File: rtl/vscale_md_iter_pkg.sv
// vscale_md_iter_pkg
// Shared multiply/divide constants for the vscale core: operation codes,
// result selects, the iterative unit's state encoding and a small helper
// that takes the magnitude of an operand when it is to be treated as signed.
package vscale_md_iter_pkg;

  localparam int XPR_LEN = 32;

  localparam int MD_OP_WIDTH = 2;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

  localparam int MD_OUT_SEL_WIDTH = 2;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_LO  = 2'd0;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_HI  = 2'd1;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_REM = 2'd2;

  localparam int MD_STATE_WIDTH = 2;
  typedef enum logic [MD_STATE_WIDTH-1:0] {
    MD_STATE_IDLE    = 2'd0,
    MD_STATE_COMPUTE = 2'd1,
    MD_STATE_FINAL   = 2'd2,
    MD_STATE_DONE    = 2'd3
  } md_state_t;

  // Magnitude of a value; only negative when flagged signed and MSB set.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [XPR_LEN-1:0] md_abs(input logic [XPR_LEN-1:0] value,
                                                input logic              isSigned);
    return (isSigned && value[XPR_LEN-1]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/vscale_md_iter.sv
// vscale_md_iter
// Iterative RV32M multiply/divide responder. Operands are reduced to
// magnitudes on acceptance, processed one bit per cycle for 32 cycles
// (shift-add multiply or restoring division), sign-corrected in a final
// cycle and returned with a one-cycle resp_valid pulse.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_op, req_out_sel operation and result select
//   req_in_1_signed/req_in_2_signed  operand signedness
//   req_in_1, req_in_2  operands (multiplicand/dividend, multiplier/divisor)
//   kill                abandon any in-flight operation
//   resp_valid          one-cycle result strobe
//   resp_result         registered result, held until the next operation finishes
module vscale_md_iter
  import vscale_md_iter_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [MD_OP_WIDTH-1:0]      req_op,
  input  logic                        req_in_1_signed,
  input  logic                        req_in_2_signed,
  input  logic [MD_OUT_SEL_WIDTH-1:0] req_out_sel,
  input  logic [XPR_LEN-1:0]          req_in_1,
  input  logic [XPR_LEN-1:0]          req_in_2,
  input  logic                        kill,
  output logic                        resp_valid,
  output logic [XPR_LEN-1:0]          resp_result
);

  md_state_t                   r_state;
  logic [4:0]                  r_count;
  logic [MD_OP_WIDTH-1:0]      r_op;
  logic [MD_OUT_SEL_WIDTH-1:0] r_out_sel;
  logic [XPR_LEN-1:0]          r_a;
  logic [XPR_LEN-1:0]          r_b;
  logic [2*XPR_LEN-1:0]        r_acc;
  logic                        r_negate_q;
  logic                        r_negate_r;
  logic                        r_in2_zero;
  logic                        r_resp_valid;
  logic [XPR_LEN-1:0]          r_resp_result;

  logic [XPR_LEN:0]            w_add_src;
  logic [XPR_LEN:0]            w_mul_sum;
  logic [XPR_LEN:0]            w_rem_shift;
  logic                        w_div_ge;
  logic [XPR_LEN-1:0]          w_div_diff;
  logic [2*XPR_LEN-1:0]        w_product;
  logic [XPR_LEN-1:0]          w_quotient;
  logic [XPR_LEN-1:0]          w_remainder;
  logic [XPR_LEN-1:0]          w_final;

  assign req_ready   = (r_state == MD_STATE_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_result = r_resp_result;

  // Per-iteration datapath and final sign correction.
  // Multiply: r_a is the multiplicand, r_b the multiplier shifting out from
  // the LSB, r_acc the running product whose top half takes the 33-bit sum.
  // Divide: r_a is the divisor, r_b the dividend shifting out from the MSB,
  // r_acc[63:32] the partial remainder and r_acc[31:0] collects quotient bits.
  // The shifted remainder can reach 33 bits, so the compare is done at that
  // width; once it passes, the difference always fits back into 32 bits.
  // A zero divisor passes every compare, leaving quotient all ones and the
  // remainder equal to the dividend magnitude, which gives RV32M results.
  always_comb begin
    w_add_src   = r_b[0] ? {1'b0, r_a} : '0;
    w_mul_sum   = {1'b0, r_acc[63:32]} + w_add_src;
    w_rem_shift = {r_acc[63:32], r_b[31]};
    w_div_ge    = (w_rem_shift >= {1'b0, r_a});
    w_div_diff  = w_rem_shift[31:0] - r_a;
    w_product   = r_negate_q ? (~r_acc + 64'd1) : r_acc;
    w_quotient  = (r_negate_q && !r_in2_zero) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    w_remainder = r_negate_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    w_final     = w_product[31:0];
    case (r_op)
      MD_OP_MUL: begin
        case (r_out_sel)
          MD_OUT_HI: w_final = w_product[63:32];
          MD_OUT_LO: w_final = w_product[31:0];
          default:   w_final = w_product[31:0];
        endcase
      end
      MD_OP_DIV: w_final = w_quotient;
      MD_OP_REM: w_final = w_remainder;
      default:   w_final = (r_out_sel == MD_OUT_REM) ? w_remainder : w_quotient;
    endcase
  end

  // Control FSM and datapath registers. kill and reset both drop the
  // machine back to idle without touching resp_result for kill; reset also
  // clears the result. A request presented together with kill is refused.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= MD_STATE_IDLE;
      r_count       <= '0;
      r_op          <= '0;
      r_out_sel     <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_acc         <= '0;
      r_negate_q    <= 1'b0;
      r_negate_r    <= 1'b0;
      r_in2_zero    <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_result <= '0;
    end else if (kill) begin
      r_state      <= MD_STATE_IDLE;
      r_count      <= '0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        MD_STATE_IDLE: begin
          r_resp_valid <= 1'b0;
          if (req_valid) begin
            r_op       <= req_op;
            r_out_sel  <= req_out_sel;
            r_a        <= (req_op == MD_OP_MUL) ? md_abs(req_in_1, req_in_1_signed)
                                                : md_abs(req_in_2, req_in_2_signed);
            r_b        <= (req_op == MD_OP_MUL) ? md_abs(req_in_2, req_in_2_signed)
                                                : md_abs(req_in_1, req_in_1_signed);
            r_in2_zero <= (req_in_2 == '0);
            r_negate_q <= (req_in_1_signed & req_in_1[31]) ^ (req_in_2_signed & req_in_2[31]);
            r_negate_r <= req_in_1_signed & req_in_1[31];
            r_acc      <= '0;
            r_count    <= '0;
            r_state    <= MD_STATE_COMPUTE;
          end
        end
        MD_STATE_COMPUTE: begin
          if (r_op == MD_OP_MUL) begin
            r_acc <= {w_mul_sum, r_acc[31:1]};
            r_b   <= r_b >> 1;
          end else begin
            r_acc <= {(w_div_ge ? w_div_diff : w_rem_shift[31:0]), r_acc[30:0], w_div_ge};
            r_b   <= r_b << 1;
          end
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) begin
            r_state <= MD_STATE_FINAL;
          end
        end
        MD_STATE_FINAL: begin
          r_resp_result <= w_final;
          r_resp_valid  <= 1'b1;
          r_state       <= MD_STATE_DONE;
        end
        MD_STATE_DONE: begin
          r_resp_valid <= 1'b0;
          r_state      <= MD_STATE_IDLE;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= MD_STATE_IDLE;
        end
      endcase
    end
  end

endmodule
